// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
//   Top-level Sudoku game sequencer. Loads a puzzle through board_selector
//   (board_enable / board_sel), keeps the working board and the fixed-cell
//   status, handles cursor moves and digit entry on editable cells, and runs a
//   one-cell-per-cycle solution check.
//   Optional feature: define MOVE_COUNT_EN to add the move_count output, a
//   saturating count of accepted digit writes.
// -----------------------------------------------------------------------------
module game_controller #(
  parameter int SIZE   = 9,
  parameter int BOX    = 3,
  parameter int CELL_W = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     sel_in,
  input  logic                                     btn_up,
  input  logic                                     btn_down,
  input  logic                                     btn_left,
  input  logic                                     btn_right,
  input  logic                                     digit_valid,
  input  logic [CELL_W-1:0]                        digit,
  input  logic                                     check_req,
  input  logic [SIZE-1:0][SIZE-1:0][CELL_W-1:0]    loaded_board,
  input  logic [SIZE-1:0][SIZE-1:0][CELL_W-1:0]    loaded_status,
  output logic                                     board_enable,
  output logic                                     board_sel,
  output logic [SIZE-1:0][SIZE-1:0][CELL_W-1:0]    play_board,
  output logic [SIZE-1:0][SIZE-1:0][CELL_W-1:0]    play_status,
  output logic [3:0]                               cursor_row,
  output logic [3:0]                               cursor_col,
  output logic                                     busy,
  output logic                                     check_fail,
  output logic                                     solved
`ifdef MOVE_COUNT_EN
  ,
  output logic [9:0]                               move_count
`endif
);

  localparam logic [3:0]        LAST      = 4'(SIZE - 1);
  localparam logic [3:0]        BOX_W     = 4'(BOX);
  localparam logic [CELL_W-1:0] MAX_DIGIT = CELL_W'(9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_PLAY,
    S_CHECK,
    S_SOLVED
  } state_t;

  state_t state, next_state;

  logic [3:0]        scan_row, scan_col;
  logic [3:0]        box_row0, box_col0;
  logic [3:0]        peer_row, peer_col;
  logic [CELL_W-1:0] scan_val;
  logic              cell_fail;
  logic              write_ok;

  // A digit lands only on an editable cell and only if it is 0..9.
  assign write_ok = digit_valid && (digit <= MAX_DIGIT) &&
                    (play_status[cursor_row][cursor_col] == '0);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: every sequential assignment is non-blocking so all flops update
    // together on the edge, independent of statement order.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latch).
    next_state   = state;
    board_enable = 1'b0;
    busy         = 1'b0;
    solved       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD;
      end
      S_LOAD: begin
        board_enable = 1'b1;
        busy         = 1'b1;
        next_state   = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy       = 1'b1;
        next_state = S_PLAY;
      end
      S_PLAY: begin
        if (start)          next_state = S_LOAD;
        else if (check_req) next_state = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (cell_fail)                                  next_state = S_PLAY;
        else if (scan_row == LAST && scan_col == LAST)  next_state = S_SOLVED;
      end
      S_SOLVED: begin
        solved = 1'b1;
        if (start) next_state = S_LOAD;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Rule check for the cell under the scan index: empty, or a repeat among
  // its 8 row peers, 8 column peers and the 4 box peers not already covered.
  always_comb begin
    scan_val  = play_board[scan_row][scan_col];
    box_row0  = (scan_row / BOX_W) * BOX_W;
    box_col0  = (scan_col / BOX_W) * BOX_W;
    peer_row  = '0;
    peer_col  = '0;
    cell_fail = (scan_val == '0);
    for (int i = 0; i < SIZE; i++) begin
      if (4'(i) != scan_col && play_board[scan_row][4'(i)] == scan_val) cell_fail = 1'b1;
      if (4'(i) != scan_row && play_board[4'(i)][scan_col] == scan_val) cell_fail = 1'b1;
    end
    for (int dr = 0; dr < BOX; dr++) begin
      for (int dc = 0; dc < BOX; dc++) begin
        peer_row = box_row0 + 4'(dr);
        peer_col = box_col0 + 4'(dc);
        if (peer_row != scan_row && peer_col != scan_col &&
            play_board[peer_row][peer_col] == scan_val)
          cell_fail = 1'b1;
      end
    end
  end

  // Datapath: puzzle capture, digit entry, cursor moves and the check scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the board and status arrays are flop banks, not a RAM, so they
      // are cleared by reset like any other register.
      board_sel   <= 1'b0;
      play_board  <= '0;
      play_status <= '0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      scan_row    <= '0;
      scan_col    <= '0;
      check_fail  <= 1'b0;
`ifdef MOVE_COUNT_EN
      move_count  <= '0;
`endif
    end else begin
      check_fail <= 1'b0;
      unique case (state)
        S_IDLE, S_SOLVED: begin
          if (start) board_sel <= sel_in;
        end
        S_CAPTURE: begin
          play_board  <= loaded_board;
          play_status <= loaded_status;
          cursor_row  <= '0;
          cursor_col  <= '0;
`ifdef MOVE_COUNT_EN
          move_count  <= '0;
`endif
        end
        S_PLAY: begin
          if (start) begin
            board_sel <= sel_in;
          end else begin
            if (check_req) begin
              scan_row <= '0;
              scan_col <= '0;
            end
            // The write uses the pre-move cursor; the move lands alongside it.
            if (write_ok) begin
              play_board[cursor_row][cursor_col] <= digit;
`ifdef MOVE_COUNT_EN
              if (move_count != 10'h3FF) move_count <= move_count + 10'd1;
`endif
            end
            if (btn_up)
              cursor_row <= (cursor_row == '0)  ? LAST : cursor_row - 4'd1;
            else if (btn_down)
              cursor_row <= (cursor_row == LAST) ? '0  : cursor_row + 4'd1;
            else if (btn_left)
              cursor_col <= (cursor_col == '0)  ? LAST : cursor_col - 4'd1;
            else if (btn_right)
              cursor_col <= (cursor_col == LAST) ? '0  : cursor_col + 4'd1;
          end
        end
        S_CHECK: begin
          if (cell_fail) begin
            check_fail <= 1'b1;
          end else if (scan_col == LAST) begin
            scan_col <= '0;
            scan_row <= scan_row + 4'd1;
          end else begin
            scan_col <= scan_col + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
